// File: rtl/rv32_pipe_pkg.sv
// Shared RV32 pipeline definitions: datapath widths and control-field encodings.
package rv32_pipe_pkg;

    localparam int XLEN    = 32;
    localparam int ALUOP_W = 5;
    localparam int REG_W   = 5;

    // ALU operation encodings carried in the ALU opcode field
    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9,
        ALU_LUI  = 5'd10,
        ALU_MUL  = 5'd11,
        ALU_DIV  = 5'd12,
        ALU_REM  = 5'd13
    } alu_op_e;

    // Write-back source select
    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_CSR = 2'd3
    } wb_sel_e;

    // Branch / jump kind; zero means no control transfer
    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_BEQ  = 4'd1,
        BR_BNE  = 4'd2,
        BR_BLT  = 4'd3,
        BR_BGE  = 4'd4,
        BR_BLTU = 4'd5,
        BR_BGEU = 4'd6,
        BR_JAL  = 4'd7,
        BR_JALR = 4'd8
    } br_jmp_e;

    // Immediate format select used by the decoder
    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

endpackage

// File: rtl/lu_hazard_detect.sv
// Load-use hazard detector: a load sitting in EX whose destination is read
// by the instruction in ID must be separated from it by one bubble.
module lu_hazard_detect
    import rv32_pipe_pkg::*;
(
    input  logic             ex_valid_i,
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             id_valid_i,
    input  logic             id_uses_rs1_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             flush_i,
    input  logic             hold_i,
    output logic             lu_stall_o
);

    logic load_in_ex;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is never a real producer, so a load to x0 cannot create a hazard.
    // Flush and hold take priority over the bubble, so the stall is masked then.
    always_comb begin
        load_in_ex = ex_valid_i && ex_mem_read_i && (ex_rd_i != '0);
        rs1_hit    = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
        rs2_hit    = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
        lu_stall_o = load_in_ex && id_valid_i && (rs1_hit || rs2_hit)
                     && !flush_i && !hold_i;
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with flush, hold and load-use bubble insertion.
module id_ex_pipe_reg #(
    parameter int XLEN    = rv32_pipe_pkg::XLEN,
    parameter int ALUOP_W = rv32_pipe_pkg::ALUOP_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold_i,
    input  logic               flush_i,
    input  logic               id_valid_i,
    input  logic [XLEN-1:0]    id_pc_i,
    input  logic [XLEN-1:0]    id_data1_i,
    input  logic [XLEN-1:0]    id_data2_i,
    input  logic [XLEN-1:0]    id_imm_ext_i,
    input  logic [4:0]         id_rs1_i,
    input  logic [4:0]         id_rs2_i,
    input  logic [4:0]         id_rd_i,
    input  logic               id_uses_rs1_i,
    input  logic               id_uses_rs2_i,
    input  logic [ALUOP_W-1:0] id_alu_op_i,
    input  logic [2:0]         id_funct3_i,
    input  logic               id_alu_src1_i,
    input  logic               id_alu_src2_i,
    input  logic [1:0]         id_wb_sel_i,
    input  logic               id_reg_write_i,
    input  logic               id_mem_read_i,
    input  logic               id_mem_write_i,
    input  logic [3:0]         id_br_jmp_i,
    output logic               ex_valid_o,
    output logic [XLEN-1:0]    ex_pc_o,
    output logic [XLEN-1:0]    ex_data1_o,
    output logic [XLEN-1:0]    ex_data2_o,
    output logic [XLEN-1:0]    ex_imm_ext_o,
    output logic [4:0]         ex_rs1_o,
    output logic [4:0]         ex_rs2_o,
    output logic [4:0]         ex_rd_o,
    output logic               ex_uses_rs1_o,
    output logic               ex_uses_rs2_o,
    output logic [ALUOP_W-1:0] ex_alu_op_o,
    output logic [2:0]         ex_funct3_o,
    output logic               ex_alu_src1_o,
    output logic               ex_alu_src2_o,
    output logic [1:0]         ex_wb_sel_o,
    output logic               ex_reg_write_o,
    output logic               ex_mem_read_o,
    output logic               ex_mem_write_o,
    output logic [3:0]         ex_br_jmp_o,
    output logic               lu_stall_o
);

    import rv32_pipe_pkg::*;

    typedef struct packed {
        logic               valid;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    data1;
        logic [XLEN-1:0]    data2;
        logic [XLEN-1:0]    imm_ext;
        logic [REG_W-1:0]   rs1;
        logic [REG_W-1:0]   rs2;
        logic [REG_W-1:0]   rd;
        logic               uses_rs1;
        logic               uses_rs2;
        logic [ALUOP_W-1:0] alu_op;
        logic [2:0]         funct3;
        logic               alu_src1;
        logic               alu_src2;
        logic [1:0]         wb_sel;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic [3:0]         br_jmp;
    } stage_t;

    stage_t id_s;
    stage_t ex_d;
    stage_t ex_q;
    logic   lu_stall;

    assign id_s = '{
        valid:     id_valid_i,
        pc:        id_pc_i,
        data1:     id_data1_i,
        data2:     id_data2_i,
        imm_ext:   id_imm_ext_i,
        rs1:       id_rs1_i,
        rs2:       id_rs2_i,
        rd:        id_rd_i,
        uses_rs1:  id_uses_rs1_i,
        uses_rs2:  id_uses_rs2_i,
        alu_op:    id_alu_op_i,
        funct3:    id_funct3_i,
        alu_src1:  id_alu_src1_i,
        alu_src2:  id_alu_src2_i,
        wb_sel:    id_wb_sel_i,
        reg_write: id_reg_write_i,
        mem_read:  id_mem_read_i,
        mem_write: id_mem_write_i,
        br_jmp:    id_br_jmp_i
    };

    lu_hazard_detect u_lu_hazard_detect (
        .ex_valid_i    (ex_q.valid),
        .ex_mem_read_i (ex_q.mem_read),
        .ex_rd_i       (ex_q.rd),
        .id_valid_i    (id_valid_i),
        .id_uses_rs1_i (id_uses_rs1_i),
        .id_rs1_i      (id_rs1_i),
        .id_uses_rs2_i (id_uses_rs2_i),
        .id_rs2_i      (id_rs2_i),
        .flush_i       (flush_i),
        .hold_i        (hold_i),
        .lu_stall_o    (lu_stall)
    );

    // Next-state select: flush, then hold, then bubble, then normal load.
    // A bubble is the same all-zero slot a flush produces.
    always_comb begin
        ex_d = ex_q;
        if (flush_i) begin
            ex_d = '0;
        end else if (hold_i) begin
            ex_d = ex_q;
        end else if (lu_stall) begin
            ex_d = '0;
        end else begin
            ex_d = id_s;
            if (!id_valid_i) begin
                ex_d.reg_write = 1'b0;
                ex_d.mem_read  = 1'b0;
                ex_d.mem_write = 1'b0;
                ex_d.br_jmp    = '0;
            end
        end
    end

    // Stage register; reset empties the EX slot without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid_o     = ex_q.valid;
    assign ex_pc_o        = ex_q.pc;
    assign ex_data1_o     = ex_q.data1;
    assign ex_data2_o     = ex_q.data2;
    assign ex_imm_ext_o   = ex_q.imm_ext;
    assign ex_rs1_o       = ex_q.rs1;
    assign ex_rs2_o       = ex_q.rs2;
    assign ex_rd_o        = ex_q.rd;
    assign ex_uses_rs1_o  = ex_q.uses_rs1;
    assign ex_uses_rs2_o  = ex_q.uses_rs2;
    assign ex_alu_op_o    = ex_q.alu_op;
    assign ex_funct3_o    = ex_q.funct3;
    assign ex_alu_src1_o  = ex_q.alu_src1;
    assign ex_alu_src2_o  = ex_q.alu_src2;
    assign ex_wb_sel_o    = ex_q.wb_sel;
    assign ex_reg_write_o = ex_q.reg_write;
    assign ex_mem_read_o  = ex_q.mem_read;
    assign ex_mem_write_o = ex_q.mem_write;
    assign ex_br_jmp_o    = ex_q.br_jmp;
    assign lu_stall_o     = lu_stall;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for the ID/EX pipeline register.
module tb_id_ex_pipe_reg;

    localparam int XLEN    = 32;
    localparam int ALUOP_W = 5;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               hold_i, flush_i, id_valid_i;
    logic [XLEN-1:0]    id_pc_i, id_data1_i, id_data2_i, id_imm_ext_i;
    logic [4:0]         id_rs1_i, id_rs2_i, id_rd_i;
    logic               id_uses_rs1_i, id_uses_rs2_i;
    logic [ALUOP_W-1:0] id_alu_op_i;
    logic [2:0]         id_funct3_i;
    logic               id_alu_src1_i, id_alu_src2_i;
    logic [1:0]         id_wb_sel_i;
    logic               id_reg_write_i, id_mem_read_i, id_mem_write_i;
    logic [3:0]         id_br_jmp_i;
    logic               ex_valid_o;
    logic [XLEN-1:0]    ex_pc_o, ex_data1_o, ex_data2_o, ex_imm_ext_o;
    logic [4:0]         ex_rs1_o, ex_rs2_o, ex_rd_o;
    logic               ex_uses_rs1_o, ex_uses_rs2_o;
    logic [ALUOP_W-1:0] ex_alu_op_o;
    logic [2:0]         ex_funct3_o;
    logic               ex_alu_src1_o, ex_alu_src2_o;
    logic [1:0]         ex_wb_sel_o;
    logic               ex_reg_write_o, ex_mem_read_o, ex_mem_write_o;
    logic [3:0]         ex_br_jmp_o;
    logic               lu_stall_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.XLEN(XLEN), .ALUOP_W(ALUOP_W)) dut (
        .clk(clk), .rst_n(rst_n), .hold_i(hold_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_pc_i(id_pc_i), .id_data1_i(id_data1_i),
        .id_data2_i(id_data2_i), .id_imm_ext_i(id_imm_ext_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
        .id_alu_op_i(id_alu_op_i), .id_funct3_i(id_funct3_i),
        .id_alu_src1_i(id_alu_src1_i), .id_alu_src2_i(id_alu_src2_i),
        .id_wb_sel_i(id_wb_sel_i), .id_reg_write_i(id_reg_write_i),
        .id_mem_read_i(id_mem_read_i), .id_mem_write_i(id_mem_write_i),
        .id_br_jmp_i(id_br_jmp_i),
        .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_data1_o(ex_data1_o),
        .ex_data2_o(ex_data2_o), .ex_imm_ext_o(ex_imm_ext_o),
        .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
        .ex_uses_rs1_o(ex_uses_rs1_o), .ex_uses_rs2_o(ex_uses_rs2_o),
        .ex_alu_op_o(ex_alu_op_o), .ex_funct3_o(ex_funct3_o),
        .ex_alu_src1_o(ex_alu_src1_o), .ex_alu_src2_o(ex_alu_src2_o),
        .ex_wb_sel_o(ex_wb_sel_o), .ex_reg_write_o(ex_reg_write_o),
        .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o),
        .ex_br_jmp_o(ex_br_jmp_o), .lu_stall_o(lu_stall_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        hold_i = 0; flush_i = 0; id_valid_i = 0;
        id_pc_i = '0; id_data1_i = '0; id_data2_i = '0; id_imm_ext_i = '0;
        id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0;
        id_uses_rs1_i = 0; id_uses_rs2_i = 0;
        id_alu_op_i = '0; id_funct3_i = '0; id_alu_src1_i = 0; id_alu_src2_i = 0;
        id_wb_sel_i = '0; id_reg_write_i = 0; id_mem_read_i = 0; id_mem_write_i = 0;
        id_br_jmp_i = '0;
    endtask

    // Present a load "lw rd" in ID
    task automatic drive_lw(input logic [4:0] rd);
        clear_id();
        id_valid_i = 1; id_rd_i = rd; id_rs1_i = 5'd2; id_uses_rs1_i = 1;
        id_mem_read_i = 1; id_reg_write_i = 1; id_wb_sel_i = 2'd1;
        id_pc_i = 32'h0000_0200;
    endtask

    initial begin
        clear_id();
        id_pc_i = 32'hDEAD_BEEF; id_valid_i = 1; id_reg_write_i = 1;
        rst_n = 0;
        #12;
        // Reset state
        chk("rst_valid", ex_valid_o, 0);
        chk("rst_pc", ex_pc_o, 0);
        chk("rst_regwr", ex_reg_write_o, 0);
        chk("rst_stall", lu_stall_o, 0);
        rst_n = 1;
        tick();

        // Normal load
        clear_id();
        id_valid_i = 1; id_pc_i = 32'h100; id_imm_ext_i = 32'hFFFF_FFE0; id_rd_i = 5'd5;
        id_data1_i = 32'h1111_2222; id_data2_i = 32'h3333_4444; id_rs1_i = 5'd1; id_rs2_i = 5'd2;
        id_alu_op_i = 5'd3; id_funct3_i = 3'd2; id_wb_sel_i = 2'd2; id_alu_src2_i = 1;
        id_reg_write_i = 1; id_br_jmp_i = 4'd7;
        tick();
        chk("norm_pc", ex_pc_o, 32'h100);
        chk("norm_imm", ex_imm_ext_o, 32'hFFFF_FFE0);
        chk("norm_rd", ex_rd_o, 5);
        chk("norm_valid", ex_valid_o, 1);
        chk("norm_data1", ex_data1_o, 32'h1111_2222);
        chk("norm_data2", ex_data2_o, 32'h3333_4444);
        chk("norm_aluop", ex_alu_op_o, 3);
        chk("norm_funct3", ex_funct3_o, 2);
        chk("norm_wbsel", ex_wb_sel_o, 2);
        chk("norm_src2", ex_alu_src2_o, 1);
        chk("norm_brjmp", ex_br_jmp_o, 7);
        chk("norm_rs2", ex_rs2_o, 2);

        // Load-use on rs1: lw x5 then add x6,x5,x1
        drive_lw(5'd5);
        tick();
        chk("lw_memrd", ex_mem_read_o, 1);
        clear_id();
        id_valid_i = 1; id_rs1_i = 5'd5; id_uses_rs1_i = 1; id_rs2_i = 5'd1; id_uses_rs2_i = 1;
        id_rd_i = 5'd6; id_reg_write_i = 1; id_pc_i = 32'h204;
        #1;
        chk("lu_stall_rs1", lu_stall_o, 1);
        tick();
        chk("bubble_valid", ex_valid_o, 0);
        chk("bubble_memrd", ex_mem_read_o, 0);
        chk("bubble_rd", ex_rd_o, 0);
        chk("bubble_regwr", ex_reg_write_o, 0);
        chk("bubble_stall", lu_stall_o, 0);
        tick();
        chk("dep_rd", ex_rd_o, 6);
        chk("dep_valid", ex_valid_o, 1);
        chk("dep_pc", ex_pc_o, 32'h204);
        chk("dep_stall", lu_stall_o, 0);

        // Load-use on rs2, source-use gating, ID valid gating, flush override
        drive_lw(5'd7);
        tick();
        clear_id();
        id_valid_i = 1; id_rs1_i = 5'd3; id_uses_rs1_i = 1; id_rs2_i = 5'd7; id_uses_rs2_i = 1;
        id_rd_i = 5'd9; id_mem_write_i = 1;
        #1;
        chk("lu_stall_rs2", lu_stall_o, 1);
        id_uses_rs2_i = 0;
        #1;
        chk("no_use_rs2", lu_stall_o, 0);
        id_uses_rs2_i = 1; id_valid_i = 0;
        #1;
        chk("id_invalid_nostall", lu_stall_o, 0);
        id_valid_i = 1; flush_i = 1;
        #1;
        chk("flush_masks_stall", lu_stall_o, 0);
        tick();
        chk("flush_valid", ex_valid_o, 0);
        chk("flush_rd", ex_rd_o, 0);
        chk("flush_memwr", ex_mem_write_o, 0);

        // Load to x0 never stalls
        drive_lw(5'd0);
        tick();
        clear_id();
        id_valid_i = 1; id_rs1_i = 5'd0; id_uses_rs1_i = 1; id_rd_i = 5'd8; id_pc_i = 32'h208;
        #1;
        chk("x0_stall", lu_stall_o, 0);
        tick();
        chk("x0_load_rd", ex_rd_o, 8);
        chk("x0_load_valid", ex_valid_o, 1);

        // Invalid ID slot: side effects forced off, payload still copied
        clear_id();
        id_valid_i = 0; id_pc_i = 32'h300; id_reg_write_i = 1; id_mem_write_i = 1;
        id_mem_read_i = 1; id_br_jmp_i = 4'd5; id_rd_i = 5'd4;
        tick();
        chk("inv_valid", ex_valid_o, 0);
        chk("inv_regwr", ex_reg_write_o, 0);
        chk("inv_memwr", ex_mem_write_o, 0);
        chk("inv_memrd", ex_mem_read_o, 0);
        chk("inv_brjmp", ex_br_jmp_o, 0);
        chk("inv_pc", ex_pc_o, 32'h300);

        // Hold with a load in EX: contents frozen, stall masked; flush in hold cycle 2
        drive_lw(5'd9);
        id_pc_i = 32'h400;
        tick();
        clear_id();
        hold_i = 1; id_valid_i = 1; id_rs1_i = 5'd9; id_uses_rs1_i = 1; id_pc_i = 32'h500;
        id_rd_i = 5'd12;
        #1;
        chk("hold_stall_mask", lu_stall_o, 0);
        tick();
        chk("hold1_pc", ex_pc_o, 32'h400);
        chk("hold1_rd", ex_rd_o, 9);
        chk("hold1_memrd", ex_mem_read_o, 1);
        id_pc_i = 32'h504; id_rd_i = 5'd13; flush_i = 1;
        tick();
        chk("hold_flush_valid", ex_valid_o, 0);
        chk("hold_flush_regwr", ex_reg_write_o, 0);
        chk("hold_flush_memrd", ex_mem_read_o, 0);
        chk("hold_flush_pc", ex_pc_o, 0);
        flush_i = 0; id_pc_i = 32'h508;
        tick();
        chk("hold3_pc", ex_pc_o, 0);
        chk("hold3_valid", ex_valid_o, 0);

        // Asynchronous reset between edges, then resume
        clear_id();
        id_valid_i = 1; id_reg_write_i = 1; id_pc_i = 32'h600; id_rd_i = 5'd10;
        tick();
        chk("pre_rst_valid", ex_valid_o, 1);
        #2 rst_n = 0;
        #1;
        chk("async_rst_valid", ex_valid_o, 0);
        chk("async_rst_regwr", ex_reg_write_o, 0);
        chk("async_rst_pc", ex_pc_o, 0);
        #1 rst_n = 1;
        id_pc_i = 32'h700; id_rd_i = 5'd11;
        tick();
        chk("post_rst_pc", ex_pc_o, 32'h700);
        chk("post_rst_valid", ex_valid_o, 1);
        chk("post_rst_rd", ex_rd_o, 11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
